// File: rtl/w_74hc194_seq_if.sv
// Command/result channel between a host FSM and the w_74hc194_seq sequencer.
// The host drives the command (master); the sequencer answers (slave).
`timescale 1ns/1ps
interface w_74hc194_seq_if #(
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [0:3]       cmd_data;   // bit 0 maps to Q0, written leftmost
    logic             cmd_sbit;
    logic             done;
    logic [0:3]       result;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sbit,
        input  cmd_ready, done, result, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sbit,
        output cmd_ready, done, result, err
    );
endinterface

// File: rtl/w_74hc194_seq.sv
// Command sequencer for a single W_74HC194 4-bit universal shift register.
// Accepts load / shift right / shift left / rotate right commands, drives the
// register's S, DSR, DSL and parallel pins cycle by cycle, and reports the
// final register contents with a one-cycle done pulse.
// Optional feature macro: SEQ_ROTATE_EN (defined: op 11 rotates right;
// undefined: op 11 completes immediately with err).
`timescale 1ns/1ps
module w_74hc194_seq #(
    parameter int CNT_W = 3
) (
    input  logic            CLK,
    input  logic            MR_N,
    w_74hc194_seq_if.slave  cmd,
    output logic [1:0]      sr_s,
    output logic            sr_dsr,
    output logic            sr_dsl,
    output logic [0:3]      sr_p,
    input  logic [0:3]      sr_q
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } op_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t           state, state_nxt;
    op_t              op_q, op_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       s_nxt;
    logic             dsr_r, dsr_nxt, dsl_nxt;
    logic [0:3]       p_nxt;
    logic             done_nxt, err_nxt;

    assign cmd.cmd_ready = (state == IDLE);

`ifdef SEQ_ROTATE_EN
    // Rotation feeds Q3 straight back into DSR; a register here would lag one step.
    assign sr_dsr = (state == EXEC && op_q == OP_ROR) ? sr_q[3] : dsr_r;
`else
    assign sr_dsr = dsr_r;
`endif

    // Next-state and next register-pin values; pins are registered below so
    // the shift register never sees a glitching mode.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        op_nxt    = op_q;
        cnt_nxt   = cnt_q;
        s_nxt     = sr_s;
        dsr_nxt   = dsr_r;
        dsl_nxt   = sr_dsl;
        p_nxt     = sr_p;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    op_nxt  = op_t'(cmd.cmd_op);
                    cnt_nxt = cmd.cmd_cnt;
                    s_nxt   = S_HOLD;
                    dsr_nxt = 1'b0;
                    dsl_nxt = 1'b0;
                    p_nxt   = '0;
                    unique case (op_t'(cmd.cmd_op))
                        OP_LOAD: begin
                            state_nxt = EXEC;
                            s_nxt     = S_LOAD;
                            p_nxt     = cmd.cmd_data;
                        end
                        OP_SHR: begin
                            if (cmd.cmd_cnt != '0) begin
                                state_nxt = EXEC;
                                s_nxt     = S_RIGHT;
                                dsr_nxt   = cmd.cmd_sbit;
                            end else begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                        OP_SHL: begin
                            if (cmd.cmd_cnt != '0) begin
                                state_nxt = EXEC;
                                s_nxt     = S_LEFT;
                                dsl_nxt   = cmd.cmd_sbit;
                            end else begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                        OP_ROR: begin
`ifdef SEQ_ROTATE_EN
                            if (cmd.cmd_cnt != '0) begin
                                state_nxt = EXEC;
                                s_nxt     = S_RIGHT;
                            end else begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end
`else
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            err_nxt   = 1'b1;
`endif
                        end
                    endcase
                end
            end
            EXEC: begin
                // A load takes one step; shifts finish on the step where the counter reads 1.
                if (op_q == OP_LOAD || cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    s_nxt     = S_HOLD;
                    dsr_nxt   = 1'b0;
                    dsl_nxt   = 1'b0;
                    p_nxt     = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and register-pin flops.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state    <= IDLE;
            op_q     <= OP_LOAD;
            cnt_q    <= '0;
            sr_s     <= S_HOLD;
            dsr_r    <= 1'b0;
            sr_dsl   <= 1'b0;
            sr_p     <= '0;
            cmd.done <= 1'b0;
            cmd.err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            op_q     <= op_nxt;
            cnt_q    <= cnt_nxt;
            sr_s     <= s_nxt;
            dsr_r    <= dsr_nxt;
            sr_dsl   <= dsl_nxt;
            sr_p     <= p_nxt;
            cmd.done <= done_nxt;
            cmd.err  <= err_nxt;
        end
    end

    // Capture the register contents at the edge that ends the DONE cycle.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            cmd.result <= '0;
        end else if (state == DONE) begin
            cmd.result <= sr_q;
        end
    end
endmodule

// File: tb/tb_w_74hc194_seq.sv
// Bench for w_74hc194_seq: a behavioural 74HC194 is attached to the
// sequencer's pins; an arithmetic model of each command builds a per-cycle
// expectation schedule that one compare process checks every cycle.
`timescale 1ns/1ps
module tb_w_74hc194_seq;
    localparam int CNT_W = 3;
`ifdef SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       MR_N;
    logic [1:0] sr_s;
    logic       sr_dsr, sr_dsl;
    logic [0:3] sr_p;
    logic [0:3] sr_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    typedef struct {
        logic       ready;
        logic [1:0] s;
        logic [0:3] p;
        logic       dsr;
        logic       dsl;
        logic       done;
        logic       err;
        logic [0:3] result;
    } exp_t;

    exp_t       exp_q[$];
    logic [0:3] idle_result = 4'b0000;
    logic [0:3] seen_result;
    int         model_val = 0;

    w_74hc194_seq_if #(.CNT_W(CNT_W)) cmd_if ();

    w_74hc194_seq #(.CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .MR_N   (MR_N),
        .cmd    (cmd_if),
        .sr_s   (sr_s),
        .sr_dsr (sr_dsr),
        .sr_dsl (sr_dsl),
        .sr_p   (sr_p),
        .sr_q   (sr_q)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Behavioural 74HC194 sharing clock and master reset.
    always @(posedge CLK or negedge MR_N) begin
        if (!MR_N) sr_q <= 4'b0000;
        else begin
            case (sr_s)
                2'b01:   sr_q <= {sr_dsr, sr_q[0:2]};
                2'b10:   sr_q <= {sr_q[1:3], sr_dsl};
                2'b11:   sr_q <= sr_p;
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, 1 ns after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (cmp_en) begin
            exp_t e;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{ready: 1'b1, s: 2'b00, p: 4'b0000, dsr: 1'b0, dsl: 1'b0,
                       done: 1'b0, err: 1'b0, result: idle_result};
            check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(e.ready));
            check("sr_s",      32'(sr_s),             32'(e.s));
            check("sr_p",      32'(sr_p),             32'(e.p));
            check("sr_dsr",    32'(sr_dsr),           32'(e.dsr));
            check("sr_dsl",    32'(sr_dsl),           32'(e.dsl));
            check("done",      32'(cmd_if.done),      32'(e.done));
            check("err",       32'(cmd_if.err),       32'(e.err));
            check("result",    32'(cmd_if.result),    32'(e.result));
        end
    end

    task automatic drive_idle();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_cnt   = '0;
        cmd_if.cmd_data  = 4'b0000;
        cmd_if.cmd_sbit  = 1'b0;
    endtask

    // Called at a falling edge; waits for ready, schedules expectations,
    // presents the command and returns at the falling edge after acceptance.
    task automatic issue(input logic [1:0] op, input int cnt, input logic [0:3] data,
                         input logic sbit, output int acc_cyc);
        int   guard = 0;
        int   v     = model_val;
        exp_t e;
        while (cmd_if.cmd_ready !== 1'b1 && guard < 64) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 64) check("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
        seen_result = cmd_if.result;

        e = '{ready: 1'b0, s: 2'b00, p: 4'b0000, dsr: 1'b0, dsl: 1'b0,
              done: 1'b0, err: 1'b0, result: idle_result};
        if (op == 2'b00) begin
            e.s = 2'b11;
            e.p = data;
            exp_q.push_back(e);
            v = int'(data);
        end else if (cnt > 0 && (op != 2'b11 || ROT_EN)) begin
            for (int i = 0; i < cnt; i++) begin
                e.s   = (op == 2'b10) ? 2'b10 : 2'b01;
                e.dsr = (op == 2'b01) ? sbit : (op == 2'b11) ? v[0] : 1'b0;
                e.dsl = (op == 2'b10) ? sbit : 1'b0;
                exp_q.push_back(e);
                case (op)
                    2'b01:   v = (v >> 1) | (int'(sbit) << 3);
                    2'b10:   v = ((v << 1) & 15) | int'(sbit);
                    default: v = (v >> 1) | ((v & 1) << 3);
                endcase
            end
        end
        e = '{ready: 1'b0, s: 2'b00, p: 4'b0000, dsr: 1'b0, dsl: 1'b0,
              done: 1'b1, err: (op == 2'b11 && !ROT_EN), result: idle_result};
        exp_q.push_back(e);
        model_val   = v;
        idle_result = 4'(v);

        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = CNT_W'(cnt);
        cmd_if.cmd_data  = data;
        cmd_if.cmd_sbit  = sbit;
        @(negedge CLK);
        acc_cyc = cyc;
        drive_idle();
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 300) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input int cnt,
                       input logic [0:3] data, input logic sbit, input logic [0:3] exp_res);
        int a;
        issue(op, cnt, data, sbit, a);
        wait_done();
        @(negedge CLK);
        check(name, 32'(cmd_if.result), 32'(exp_res));
        check({name, "_model"}, 32'(model_val), 32'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2;
        drive_idle();
        MR_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready",  32'(cmd_if.cmd_ready), 32'd1);
        check("rst_sr_s",   32'(sr_s),             32'd0);
        check("rst_done",   32'(cmd_if.done),      32'd0);
        check("rst_result", 32'(cmd_if.result),    32'd0);
        cmp_en = 1'b1;
        MR_N   = 1'b1;
        @(negedge CLK);

        run("load_1010", 2'b00, 0, 4'b1010, 1'b0, 4'b1010);

        run("load_1000", 2'b00, 0, 4'b1000, 1'b0, 4'b1000);
        run("shr3_fill1", 2'b01, 3, 4'b0000, 1'b1, 4'b1111);
        run("shr1_fill0", 2'b01, 1, 4'b0000, 1'b0, 4'b0111);

        run("load_0001", 2'b00, 0, 4'b0001, 1'b0, 4'b0001);
        issue(2'b10, 2, 4'b0000, 1'b0, acc1);
        wait_done();
        issue(2'b00, 0, 4'b0011, 1'b0, acc2);
        check("shl2_result", 32'(seen_result), 32'(4'b0100));
        check("shl2_spacing", 32'(acc2 - acc1), 32'd4);
        wait_done();
        @(negedge CLK);

        run("load_1000b", 2'b00, 0, 4'b1000, 1'b0, 4'b1000);
        run("ror4", 2'b11, 4, 4'b0000, 1'b0, 4'b1000);
        run("shr0_nochange", 2'b01, 0, 4'b0000, 1'b1, 4'b1000);

        // A second command presented while busy must be ignored.
        issue(2'b01, 7, 4'b0000, 1'b1, acc1);
        repeat (2) @(negedge CLK);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 4'b0101;
        repeat (3) @(negedge CLK);
        drive_idle();
        wait_done();
        @(negedge CLK);
        check("busy_ignored", 32'(cmd_if.result), 32'(4'b1111));

        // Reset in the middle of a long shift.
        issue(2'b01, 7, 4'b0000, 1'b0, acc1);
        repeat (3) @(negedge CLK);
        exp_q.delete();
        model_val   = 0;
        idle_result = 4'b0000;
        MR_N        = 1'b0;
        #1;
        check("mr_sr_s",   32'(sr_s),             32'd0);
        check("mr_sr_p",   32'(sr_p),             32'd0);
        check("mr_dsr",    32'(sr_dsr),           32'd0);
        check("mr_dsl",    32'(sr_dsl),           32'd0);
        check("mr_done",   32'(cmd_if.done),      32'd0);
        check("mr_err",    32'(cmd_if.err),       32'd0);
        check("mr_ready",  32'(cmd_if.cmd_ready), 32'd1);
        check("mr_result", 32'(cmd_if.result),    32'd0);
        check("mr_sr_q",   32'(sr_q),             32'd0);
        repeat (2) @(negedge CLK);
        MR_N = 1'b1;
        @(negedge CLK);
        run("post_rst_load", 2'b00, 0, 4'b0110, 1'b0, 4'b0110);
        run("post_rst_shl1", 2'b10, 1, 4'b0000, 1'b1, 4'b1101);

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
